// File: rtl/lab1_sequencer_pkg.sv
// Shared types and the golden function for the lab1 self-test sequencer.
// The golden function is NOT majority(A,B,C), the expected gate network output.
package lab1_sequencer_pkg;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] VEC_LAST = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic golden(
    input logic a,
    input logic b,
    input logic c
  );
    return ~((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/lab1_sequencer_golden.sv
// Combinational golden model of the lab1 network: D_EXP = NOT majority.
// Kept as a module so a scoreboard can instantiate the same reference.
module lab1_sequencer_golden
  import lab1_sequencer_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic C,
  output logic D_EXP
);

  assign D_EXP = golden(A, B, C);

endmodule

// File: rtl/lab1_sequencer.sv
// Self-test sequencer: steps {A,B,C} through 000..111, samples D after a
// settle time, and reports pass/fail, error count and first failing vector.
module lab1_sequencer
  import lab1_sequencer_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       D,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_COUNT,
  output logic [2:0] FAIL_VEC
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t           r_state;
  logic [VEC_W-1:0] r_vec;
  logic [VEC_W-1:0] r_abc;
  logic [7:0]       r_cnt;
  logic [3:0]       r_err;
  logic [2:0]       r_fv;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic       w_d_exp;
  logic       w_miss;
  logic [3:0] w_err_nxt;

  lab1_sequencer_golden u_golden (
    .A     (r_vec[2]),
    .B     (r_vec[1]),
    .C     (r_vec[0]),
    .D_EXP (w_d_exp)
  );

  assign w_miss    = (D != w_d_exp);
  assign w_err_nxt = r_err + {3'b000, w_miss};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_abc   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_fv    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        // DONE restarts exactly like IDLE; results clear on the same edge
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state <= S_WAIT;
            r_vec   <= '0;
            r_abc   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_fv    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_miss && r_err == 4'd0) begin
            r_fv <= r_vec;
          end
          if (r_vec == VEC_LAST) begin
            r_state <= S_DONE;
            r_abc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 4'd0);
          end else begin
            r_state <= S_WAIT;
            r_vec   <= r_vec + 3'd1;
            r_abc   <= r_vec + 3'd1;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign A         = r_abc[2];
  assign B         = r_abc[1];
  assign C         = r_abc[0];
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign ERR_COUNT = r_err;
  assign FAIL_VEC  = r_fv;

endmodule

// File: tb/tb_lab1_sequencer.sv
// Directed bench for lab1_sequencer: SETTLE=4 and SETTLE=1 instances,
// with D driven by a behavioural network that can be stuck at 0 or 1.
module tb_lab1_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=4 instance
  logic       rst4, st4, d4;
  logic       a4, b4, c4, busy4, done4, pass4;
  logic [3:0] err4;
  logic [2:0] fv4;
  int         mode4;

  // SETTLE=1 instance, D stuck at 1
  logic       rst1, st1, d1;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] fv1;

  int n_cmp = 0;
  int n_err = 0;

  lab1_sequencer #(.SETTLE(4)) u_dut4 (
    .CLK(clk), .RESET(rst4), .START(st4), .D(d4),
    .A(a4), .B(b4), .C(c4),
    .BUSY(busy4), .DONE(done4), .PASS(pass4),
    .ERR_COUNT(err4), .FAIL_VEC(fv4)
  );

  lab1_sequencer #(.SETTLE(1)) u_dut1 (
    .CLK(clk), .RESET(rst1), .START(st1), .D(d1),
    .A(a1), .B(b1), .C(c1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_COUNT(err1), .FAIL_VEC(fv1)
  );

  always_comb begin
    d4 = 1'b0;
    case (mode4)
      0:       d4 = ~((a4 & b4) | (a4 & c4) | (b4 & c4));
      1:       d4 = 1'b0;
      default: d4 = 1'b1;
    endcase
  end

  assign d1 = 1'b1;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst4 = 1'b1; st4 = 1'b0; mode4 = 0;
    rst1 = 1'b1; st1 = 1'b0;
    step(2);
    rst4 = 1'b0; rst1 = 1'b0;

    chk("rst_abc",  {5'b0, a4, b4, c4}, 8'd0);
    chk("rst_busy", {7'b0, busy4}, 8'd0);
    chk("rst_done", {7'b0, done4}, 8'd0);
    chk("rst_pass", {7'b0, pass4}, 8'd0);
    chk("rst_err",  {4'b0, err4}, 8'd0);
    chk("rst_fv",   {5'b0, fv4}, 8'd0);
    step(2);
    chk("idle_busy", {7'b0, busy4}, 8'd0);

    // good network, vectors every 5 cycles
    st4 = 1'b1; step(1); st4 = 1'b0;
    chk("go_busy", {7'b0, busy4}, 8'd1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("vec%0d_lo", k), {5'b0, a4, b4, c4}, 8'(k));
      step(4);
      chk($sformatf("vec%0d_hi", k), {5'b0, a4, b4, c4}, 8'(k));
      chk($sformatf("vec%0d_pass", k), {7'b0, pass4}, 8'd0);
      step(1);
    end
    chk("good_done", {7'b0, done4}, 8'd1);
    chk("good_pass", {7'b0, pass4}, 8'd1);
    chk("good_err",  {4'b0, err4}, 8'd0);
    chk("good_fv",   {5'b0, fv4}, 8'd0);
    chk("good_busy", {7'b0, busy4}, 8'd0);
    chk("good_abc",  {5'b0, a4, b4, c4}, 8'd0);

    // stuck-at-0, with ignored START pulses at edges 3 and 12
    mode4 = 1;
    st4 = 1'b1; step(1); st4 = 1'b0;
    chk("s0_clr_done", {7'b0, done4}, 8'd0);
    step(2); st4 = 1'b1; step(1); st4 = 1'b0;
    step(8); st4 = 1'b1; step(1); st4 = 1'b0;
    step(27);
    chk("s0_e39_done", {7'b0, done4}, 8'd0);
    step(1);
    chk("s0_done", {7'b0, done4}, 8'd1);
    chk("s0_err",  {4'b0, err4}, 8'd4);
    chk("s0_fv",   {5'b0, fv4}, 8'd0);
    chk("s0_pass", {7'b0, pass4}, 8'd0);
    step(5);
    chk("s0_hold_done", {7'b0, done4}, 8'd1);
    chk("s0_hold_err",  {4'b0, err4}, 8'd4);

    // stuck-at-1, restarted from DONE
    mode4 = 2;
    st4 = 1'b1; step(1); st4 = 1'b0;
    chk("s1_clr_err",  {4'b0, err4}, 8'd0);
    chk("s1_clr_busy", {7'b0, busy4}, 8'd1);
    step(40);
    chk("s1_done", {7'b0, done4}, 8'd1);
    chk("s1_err",  {4'b0, err4}, 8'd4);
    chk("s1_fv",   {5'b0, fv4}, 8'd3);
    chk("s1_pass", {7'b0, pass4}, 8'd0);

    // reset at edge 15 of a stuck-at-0 run
    mode4 = 1;
    st4 = 1'b1; step(1); st4 = 1'b0;
    step(14);
    chk("mid_err_pre", {4'b0, err4}, 8'd2);
    chk("mid_abc_pre", {5'b0, a4, b4, c4}, 8'd2);
    rst4 = 1'b1; step(1); rst4 = 1'b0;
    chk("mid_abc",  {5'b0, a4, b4, c4}, 8'd0);
    chk("mid_busy", {7'b0, busy4}, 8'd0);
    chk("mid_err",  {4'b0, err4}, 8'd0);
    chk("mid_done", {7'b0, done4}, 8'd0);
    step(3);
    chk("mid_idle", {7'b0, busy4}, 8'd0);

    // RESET and START on the same edge
    rst4 = 1'b1; st4 = 1'b1; step(1);
    rst4 = 1'b0; st4 = 1'b0;
    chk("rs_busy", {7'b0, busy4}, 8'd0);
    step(2);
    chk("rs_idle", {7'b0, busy4}, 8'd0);

    // SETTLE=1, START held high, D stuck at 1
    st1 = 1'b1; step(1);
    chk("t1_busy", {7'b0, busy1}, 8'd1);
    step(15);
    chk("t1_e15_done", {7'b0, done1}, 8'd0);
    step(1);
    chk("t1_done", {7'b0, done1}, 8'd1);
    chk("t1_err",  {4'b0, err1}, 8'd4);
    chk("t1_fv",   {5'b0, fv1}, 8'd3);
    chk("t1_pass", {7'b0, pass1}, 8'd0);
    step(1);
    chk("t1_rst_done", {7'b0, done1}, 8'd0);
    chk("t1_rst_busy", {7'b0, busy1}, 8'd1);
    chk("t1_rst_err",  {4'b0, err1}, 8'd0);
    step(16);
    chk("t1_done2", {7'b0, done1}, 8'd1);
    st1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
